// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared op codes and FSM state type for the bit-serial logic scheduler
package lu_pkg;

    localparam logic [1:0] LU_AND  = 2'b00;
    localparam logic [1:0] LU_OR   = 2'b01;
    localparam logic [1:0] LU_NAND = 2'b10;
    localparam logic [1:0] LU_NOR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lu_state_t;

endpackage

// File: rtl/lu_serial_sched_if.sv
// rtl/lu_serial_sched_if.sv - request/result bundle between requesters, scheduler and result consumer
interface lu_serial_sched_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic [1:0]       res_op;
    logic             busy;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_op, busy
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, res_ready,
        output req_ready, res_valid, res_data, res_id, res_op, busy
    );

endinterface

// File: rtl/lu_cell.sv
// rtl/lu_cell.sv - combinational 1-bit AND/OR/NAND/NOR cell
module lu_cell
    import lu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (op)
            LU_AND:  y = a & b;
            LU_OR:   y = a | b;
            LU_NAND: y = ~(a & b);
            LU_NOR:  y = ~(a | b);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/lu_serial_sched.sv
// rtl/lu_serial_sched.sv - two-requester bit-serial scheduler around one lu_cell
// LU_SCHED_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module lu_serial_sched
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    lu_serial_sched_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    lu_state_t        state_q;
    lu_state_t        state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [1:0]       op_q;
    logic             id_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       req_ready;
    logic             grant;
    logic             accept;
    logic             last_bit;
    logic             cell_y;
    logic             ptr_q;

`ifdef LU_SCHED_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= ~grant;
        end
    end
`else
    assign ptr_q = 1'b0;
`endif

    // The pointer only matters on a tie; a lone requester always wins.
    assign grant    = (&bus.req_valid) ? ptr_q : bus.req_valid[1];
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    lu_cell u_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .op (op_q),
        .y  (cell_y)
    );

    always_comb begin
        state_nxt = state_q;
        req_ready = 2'b00;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (|bus.req_valid)) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift right so the cell always sees bit k at position 0;
    // results enter at the MSB so bit 0 lands in place after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= LU_AND;
            id_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                a_q   <= grant ? bus.req_a1  : bus.req_a0;
                b_q   <= grant ? bus.req_b1  : bus.req_b0;
                op_q  <= grant ? bus.req_op1 : bus.req_op0;
                id_q  <= grant;
                res_q <= '0;
                cnt_q <= '0;
            end else if (state_q == BUSY) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                res_q <= (res_q >> 1) | (WIDTH'(cell_y) << (WIDTH - 1));
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = res_q;
    assign bus.res_id    = id_q;
    assign bus.res_op    = op_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lu_serial_sched.sv
// tb/tb_lu_serial_sched.sv - randomized and directed checks of lu_serial_sched against a word-level model
module tb_lu_serial_sched;
    import lu_pkg::*;

    localparam int WIDTH = 8;
`ifdef LU_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;

    lu_serial_sched_if #(.WIDTH(WIDTH)) bus ();
    lu_serial_sched_if #(.WIDTH(1))     bus1 ();

    lu_serial_sched #(.WIDTH(WIDTH)) dut  (.clk(clk), .reset(reset), .bus(bus));
    lu_serial_sched #(.WIDTH(1))     dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [WIDTH-1:0] lu_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [1:0] op);
        case (op)
            LU_AND:  return a & b;
            LU_OR:   return a | b;
            LU_NAND: return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    // Word-level model: an accepted request owes its result WIDTH+1 cycles later.
    bit               m_active = 1'b0;
    int               m_acc = 0;
    logic [WIDTH-1:0] m_data = '0;
    logic             m_id = 1'b0;
    logic [1:0]       m_op = 2'b00;
    bit               m_ptr = 1'b0;
    bit               m_after_reset = 1'b0;

    always @(negedge clk) begin
        logic [1:0] exp_ready;
        logic       g;
        logic       exp_rv;
        cyc++;
        if (m_after_reset) begin
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_data", bus.res_data, 0);
            chk("rst_res_id", bus.res_id, 0);
            chk("rst_res_op", bus.res_op, 0);
            chk("rst_busy", bus.busy, 0);
        end
        g = (&bus.req_valid) ? (RR ? m_ptr : 1'b0) : bus.req_valid[1];
        if (reset || m_active || !(|bus.req_valid)) exp_ready = 2'b00;
        else exp_ready = g ? 2'b10 : 2'b01;
        exp_rv = m_active && (cyc >= m_acc + WIDTH + 1);
        chk("req_ready", bus.req_ready, exp_ready);
        chk("busy", bus.busy, m_active);
        chk("res_valid", bus.res_valid, exp_rv);
        if (exp_rv) begin
            chk("res_data", bus.res_data, m_data);
            chk("res_id", bus.res_id, m_id);
            chk("res_op", bus.res_op, m_op);
        end
        m_after_reset = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_ptr = 1'b0;
            m_after_reset = 1'b1;
        end else if (!m_active && (|bus.req_valid)) begin
            m_active = 1'b1;
            m_acc = cyc;
            m_id = g;
            m_op = g ? bus.req_op1 : bus.req_op0;
            m_data = g ? lu_word(bus.req_a1, bus.req_b1, bus.req_op1)
                       : lu_word(bus.req_a0, bus.req_b0, bus.req_op0);
            if (RR) m_ptr = ~g;
        end else if (exp_rv && bus.res_ready) begin
            m_active = 1'b0;
        end
    end

    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bit ok = 1'b0;
        if (id == 0) begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; bus.req_valid = 2'b01;
        end else begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; bus.req_valid = 2'b10;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        chk("accept_seen", ok, 1);
    endtask

    task automatic wait_result(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (bus.res_valid) break;
        end
    endtask

    task automatic run_directed(input int id, input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] op, input logic [7:0] exp);
        int n;
        bus.res_ready = 1'b1;
        issue(id, a, b, op);
        wait_result(n);
        chk("dir_latency", n, 9);
        chk("dir_data", bus.res_data, exp);
        chk("dir_id", bus.res_id, id);
        chk("dir_op", bus.res_op, op);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        int   gcnt;
        logic grants [2];
        bit   ok;

        bus.req_valid = 2'b00; bus.res_ready = 1'b1;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
        bus.req_op0 = 2'b00; bus.req_op1 = 2'b00;
        bus1.req_valid = 2'b00; bus1.res_ready = 1'b1;
        bus1.req_a0 = 1'b0; bus1.req_b0 = 1'b0; bus1.req_a1 = 1'b0; bus1.req_b1 = 1'b0;
        bus1.req_op0 = 2'b00; bus1.req_op1 = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("init_res_valid", bus.res_valid, 0);
        chk("init_busy", bus.busy, 0);
        @(posedge clk);
        #1;

        // Tie between requesters straight after reset
        bus.req_a0 = 8'h12; bus.req_b0 = 8'h34; bus.req_op0 = LU_OR;
        bus.req_a1 = 8'h56; bus.req_b1 = 8'h78; bus.req_op1 = LU_AND;
        bus.req_valid = 2'b11;
        gcnt = 0;
        grants[0] = 1'b1; grants[1] = 1'b1;
        for (int i = 0; i < 60 && gcnt < 2; i++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                grants[gcnt] = bus.req_ready[1];
                gcnt++;
            end
        end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        chk("tie_grant_count", gcnt, 2);
        chk("tie_grant0", grants[0], 0);
        chk("tie_grant1", grants[1], RR);
        repeat (12) @(posedge clk);
        #1;

        run_directed(0, 8'hF0, 8'hCC, LU_AND,  8'hC0);
        run_directed(1, 8'hF0, 8'hCC, LU_OR,   8'hFC);
        run_directed(1, 8'hF0, 8'hCC, LU_NAND, 8'h3F);
        run_directed(1, 8'hF0, 8'hCC, LU_NOR,  8'h03);
        run_directed(0, 8'h00, 8'h00, LU_NOR,  8'hFF);

        // Result backpressure with both requesters waiting
        bus.res_ready = 1'b0;
        issue(0, 8'h5A, 8'h0F, LU_OR);
        wait_result(n);
        chk("bp_latency", n, 9);
        @(posedge clk);
        #1 bus.req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_data", bus.res_data, 8'h5F);
            chk("bp_ready", bus.req_ready, 2'b00);
            chk("bp_busy", bus.busy, 1);
            @(posedge clk);
            #1;
        end
        bus.res_ready = 1'b1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("bp_handoff_valid", bus.res_valid, 1);
        @(negedge clk);
        chk("bp_idle_valid", bus.res_valid, 0);
        chk("bp_idle_busy", bus.busy, 0);
        @(posedge clk);
        #1;

        // Reset while bit 3 is being processed
        issue(1, 8'h33, 8'h55, LU_AND);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_res_data", bus.res_data, 0);
        @(posedge clk);
        #1;
        run_directed(0, 8'hAA, 8'hFF, LU_NAND, 8'h55);

        // One-bit build: a single BUSY cycle
        bus1.req_a0 = 1'b1; bus1.req_b0 = 1'b1; bus1.req_op0 = LU_NAND; bus1.req_valid = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.req_ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 bus1.req_valid = 2'b00;
        chk("w1_accept", ok, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (bus1.res_valid) break;
        end
        chk("w1_latency", n, 2);
        chk("w1_data", bus1.res_data, 0);
        chk("w1_id", bus1.res_id, 0);
        @(posedge clk);
        #1;

        // Random traffic, backpressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            bus.req_valid = 2'($urandom);
            bus.req_a0 = 8'($urandom); bus.req_b0 = 8'($urandom); bus.req_op0 = 2'($urandom);
            bus.req_a1 = 8'($urandom); bus.req_b1 = 8'($urandom); bus.req_op1 = 2'($urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 79) == 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drain_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
